gray_updn_cnt: RTL and testbench
================================

# gray_updn_cnt

Parametrised Gray-code counter with up/down direction, synchronous clear and Gray-value load, wrap or saturate mode, and registered binary and boundary outputs. It generalises the team's fixed up-only Gray counter. It serves as the pointer and sequence generator feeding clock-domain-crossing paths. Every output is registered, so `gray_count` can go straight into a downstream synchroniser with no combinational glitches.

## Interface
- `WIDTH`, default 8: counter width in bits; must be ≥ 2.
- `SATURATE`, default 0: 0 = wrap mode, 1 = hold at the end points.
- `RESET_VAL`, default 0: binary value loaded on reset and on `clr`; must fit in `WIDTH` bits.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: count enable.
- `dir` in 1: 1 = up, 0 = down; sampled only when `en` is high.
- `clr` in 1: synchronous clear to `RESET_VAL`.
- `load` in 1: synchronous load of `load_gray`.
- `load_gray` in WIDTH: Gray-coded load value.
- `gray_count` out WIDTH: registered Gray count.
- `bin_count` out WIDTH: registered binary count.
- `at_max` out 1: registered; high when `bin_count` is all ones.
- `at_min` out 1: registered; high when `bin_count` is zero.
- `wrap` out 1: registered one-cycle pulse marking a wrap-around step.

## Operation
- Internal state is the binary count. `gray_count` is registered from `bin2gray(next_bin)` on the same edge as `bin_count`. The invariant `gray_count == bin_count ^ (bin_count >> 1)` holds on every cycle.
- Per-edge priority is `clr` > `load` > `en` > hold:
  - `clr`: next_bin = `RESET_VAL`.
  - `load`: next_bin = `gray2bin(load_gray)`.
  - `en` with `dir` = 1: next_bin = bin + 1, modulo 2^WIDTH.
  - `en` with `dir` = 0: next_bin = bin − 1, modulo 2^WIDTH.
  - Otherwise the count holds.
- Wrap mode: counting up from all ones gives 0; counting down from 0 gives all ones.
- Saturate mode: counting up at all ones holds, and counting down at 0 holds. Steps away from the end points are unaffected.
- `at_max` and `at_min` are computed from next_bin and registered, so they always describe the current `bin_count`.
- `wrap` is high for exactly the one cycle after an `en` step that crossed the all-ones↔0 boundary in wrap mode. It is never asserted in saturate mode, and never on `clr` or `load`, even if the value jumps across the boundary.
- During counting, consecutive `gray_count` values differ in exactly one bit. A held count changes no bits. A `clr` or `load` may change any number of bits.
- An arbitrary `load_gray` pattern is always legal, because every WIDTH-bit vector is a valid Gray code.

## Timing
- Reset, asynchronous on assertion:
  - `bin_count` = `RESET_VAL`.
  - `gray_count` = `bin2gray(RESET_VAL)`.
  - `at_min` = (`RESET_VAL` == 0).
  - `at_max` = (`RESET_VAL` == all ones).
  - `wrap` = 0.
- Reset mid-count takes effect immediately and discards any pending step. Release is synchronous to `clk`; the first step occurs on the first rising edge with `rst_n` high and `en` high.
- Latency: inputs sampled at edge N appear on all outputs after edge N. There is no combinational path from inputs to outputs.
- `en` may toggle every cycle, and `dir` may reverse on consecutive cycles. For example, up then down returns to the original value in two cycles with two single-bit changes.

## Structure
- Package `gray_pkg` holds:
  - functions `bin2gray(logic [WIDTH-1:0])` and `gray2bin(...)`, the latter as a prefix-XOR from the MSB down;
  - the localparams for all-ones and zero as used here.
  - Parametrise the functions with WIDTH through a parametrised class or a width-generic loop.
- One sub-module is natural: `gray2bin`, a combinational WIDTH-parameterised decoder used on the load path. It is shared with future synchronised-pointer comparators.
- Top level: next-state mux, saturate/wrap detect, and one register bank (bin, gray, at_max, at_min, wrap).

## Test plan
- **Reset** (WIDTH=4, RESET_VAL=0): assert `rst_n` low mid-count → outputs immediately gray=0, bin=0, at_min=1, at_max=0, wrap=0.
- **Up-count wrap** (WIDTH=4, SATURATE=0, `en`=1, `dir`=1, 16 cycles from 0): gray = 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0. Check exactly one bit changes per step, and `wrap`=1 only in the cycle gray returns to 0.
- **Down from 0** (WIDTH=4): one `en` step with `dir`=0 → bin=F, gray=8, wrap=1, at_max=1, at_min=0. A second step → bin=E, gray=9, wrap=0.
- **Saturate mode** (SATURATE=1): at bin=F, up steps hold gray=8 with wrap=0 and at_max=1. At bin=0, down steps hold gray=0 with at_min=1.
- **Load and priority**:
  - `load`=1 with `load_gray`=4'b0111 → next cycle bin=5, gray=7, wrap=0.
  - `clr`, `load` and `en` all high together → bin=`RESET_VAL` and no wrap.
  - `load` with `load_gray`=4'b1000 while counting → bin=F, at_max=1, wrap=0.
- **Hold and direction reversal**:
  - `en`=0 with `dir` toggling → outputs unchanged.
  - Alternating `en` up/down from bin=7 → 8,7,8,7. Check gray alternates 4,C with a single-bit change each step.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared Gray/binary conversion helpers. Functions work on a wide vector so any
// WIDTH up to MaxWidth can use them; callers zero-extend in and truncate out.
package gray_pkg;

  localparam int unsigned MaxWidth = 64;

  localparam logic [MaxWidth-1:0] AllOnes = '1;
  localparam logic [MaxWidth-1:0] Zero    = '0;

  function automatic logic [MaxWidth-1:0] bin2gray(input logic [MaxWidth-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Prefix XOR from the MSB down; zero-extended upper bits leave the result unchanged.
  function automatic logic [MaxWidth-1:0] gray2bin(input logic [MaxWidth-1:0] gray);
    logic [MaxWidth-1:0] bin;
    bin = '0;
    bin[MaxWidth-1] = gray[MaxWidth-1];
    for (int i = MaxWidth - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational WIDTH-bit Gray-to-binary decoder, reused by pointer comparators.
module gray2bin
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  always_comb begin
    bin_o = WIDTH'(gray_pkg::gray2bin(MaxWidth'(gray_i)));
  end

endmodule

// File: rtl/gray_updn_cnt.sv
// Up/down Gray counter with clear, Gray load, wrap/saturate mode and fully
// registered outputs, safe to feed straight into a CDC synchroniser.
module gray_updn_cnt
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned SATURATE  = 0,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] gray_count,
  output logic [WIDTH-1:0] bin_count,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MaxVal    = WIDTH'(AllOnes);
  localparam logic [WIDTH-1:0] MinVal    = WIDTH'(Zero);
  localparam logic [WIDTH-1:0] One       = WIDTH'(1);
  localparam logic [WIDTH-1:0] ResetBin  = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ResetGray = WIDTH'(bin2gray(MaxWidth'(ResetBin)));
  localparam bit               SatMode   = (SATURATE != 0);

  logic [WIDTH-1:0] bin_d, bin_q;
  logic [WIDTH-1:0] gray_d, gray_q;
  logic             at_max_d, at_max_q;
  logic             at_min_d, at_min_q;
  logic             wrap_d, wrap_q;
  logic [WIDTH-1:0] load_bin;

  gray2bin #(
    .WIDTH (WIDTH)
  ) u_load_dec (
    .gray_i (load_gray),
    .bin_o  (load_bin)
  );

  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (clr) begin
      bin_d = ResetBin;
    end else if (load) begin
      bin_d = load_bin;
    end else if (en) begin
      if (dir) begin
        if (bin_q == MaxVal) begin
          if (!SatMode) begin
            bin_d  = MinVal;
            wrap_d = 1'b1;
          end
        end else begin
          bin_d = bin_q + One;
        end
      end else begin
        if (bin_q == MinVal) begin
          if (!SatMode) begin
            bin_d  = MaxVal;
            wrap_d = 1'b1;
          end
        end else begin
          bin_d = bin_q - One;
        end
      end
    end
    gray_d   = WIDTH'(bin2gray(MaxWidth'(bin_d)));
    at_max_d = (bin_d == MaxVal);
    at_min_d = (bin_d == MinVal);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q    <= ResetBin;
      gray_q   <= ResetGray;
      at_max_q <= (ResetBin == MaxVal);
      at_min_q <= (ResetBin == MinVal);
      wrap_q   <= 1'b0;
    end else begin
      bin_q    <= bin_d;
      gray_q   <= gray_d;
      at_max_q <= at_max_d;
      at_min_q <= at_min_d;
      wrap_q   <= wrap_d;
    end
  end

  assign bin_count  = bin_q;
  assign gray_count = gray_q;
  assign at_max     = at_max_q;
  assign at_min     = at_min_q;
  assign wrap       = wrap_q;

endmodule

// File: tb/tb_gray_updn_cnt.sv
// Scoreboard bench: a wrap-mode and a saturate-mode counter share stimulus and are
// checked every cycle against an arithmetic reference model.
module tb_gray_updn_cnt;

  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;
  localparam int RV_W = 0;
  localparam int RV_S = 6;

  typedef struct {
    int bin;
    int gray;
    bit amax;
    bit amin;
    bit wr;
    bit bitcheck;
    bit chg;
  } exp_t;

  typedef struct {
    exp_t w;
    exp_t s;
  } pair_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         en = 1'b0, dir = 1'b0, clr = 1'b0, load = 1'b0;
  logic [W-1:0] load_gray = '0;
  logic [W-1:0] gray_w, bin_w, gray_s, bin_s;
  logic         amax_w, amin_w, wrap_w, amax_s, amin_s, wrap_s;

  int tests = 0;
  int fails = 0;
  int mb_w  = RV_W;
  int mb_s  = RV_S;
  pair_t q[$];

  always #5 clk = ~clk;

  gray_updn_cnt #(.WIDTH(W), .SATURATE(0), .RESET_VAL(RV_W)) u_wrap (
    .clk (clk), .rst_n (rst_n), .en (en), .dir (dir), .clr (clr), .load (load),
    .load_gray (load_gray), .gray_count (gray_w), .bin_count (bin_w),
    .at_max (amax_w), .at_min (amin_w), .wrap (wrap_w)
  );

  gray_updn_cnt #(.WIDTH(W), .SATURATE(1), .RESET_VAL(RV_S)) u_sat (
    .clk (clk), .rst_n (rst_n), .en (en), .dir (dir), .clr (clr), .load (load),
    .load_gray (load_gray), .gray_count (gray_s), .bin_count (bin_s),
    .at_max (amax_s), .at_min (amin_s), .wrap (wrap_s)
  );

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic int decode_gray(input int g);
    for (int v = 0; v <= MAXV; v++) begin
      if ((v ^ (v >> 1)) == g) return v;
    end
    return 0;
  endfunction

  function automatic exp_t model(input int b, input bit sat, input int rv, input bit c,
                                 input bit l, input bit e, input bit d, input int lg);
    exp_t r;
    int   nb;
    nb   = b;
    r.wr = 1'b0;
    if (c) nb = rv;
    else if (l) nb = decode_gray(lg);
    else if (e) begin
      if (d) begin
        if (b == MAXV) begin
          if (!sat) begin nb = 0; r.wr = 1'b1; end
        end else nb = b + 1;
      end else begin
        if (b == 0) begin
          if (!sat) begin nb = MAXV; r.wr = 1'b1; end
        end else nb = b - 1;
      end
    end
    r.bin      = nb;
    r.gray     = nb ^ (nb >> 1);
    r.amax     = (nb == MAXV);
    r.amin     = (nb == 0);
    r.bitcheck = !(c || l);
    r.chg      = (nb != b);
    return r;
  endfunction

  task automatic drive(input bit c, input bit l, input bit e, input bit d, input int lg);
    pair_t p;
    @(negedge clk);
    clr = c; load = l; en = e; dir = d; load_gray = W'(lg);
    p.w  = model(mb_w, 1'b0, RV_W, c, l, e, d, lg);
    p.s  = model(mb_s, 1'b1, RV_S, c, l, e, d, lg);
    mb_w = p.w.bin;
    mb_s = p.s.bin;
    q.push_back(p);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " w.bin"}, int'(bin_w), RV_W);
    chk({tag, " w.gray"}, int'(gray_w), RV_W ^ (RV_W >> 1));
    chk({tag, " w.at_min"}, int'(amin_w), int'(RV_W == 0));
    chk({tag, " w.at_max"}, int'(amax_w), int'(RV_W == MAXV));
    chk({tag, " w.wrap"}, int'(wrap_w), 0);
    chk({tag, " s.bin"}, int'(bin_s), RV_S);
    chk({tag, " s.gray"}, int'(gray_s), RV_S ^ (RV_S >> 1));
    chk({tag, " s.at_min"}, int'(amin_s), int'(RV_S == 0));
    chk({tag, " s.at_max"}, int'(amax_s), int'(RV_S == MAXV));
  endtask

  // Reset asserted just after a falling edge, with a pending up step on the inputs.
  task automatic do_reset();
    @(negedge clk);
    #2;
    en = 1'b1; dir = 1'b1; clr = 1'b0; load = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    mb_w = RV_W;
    mb_s = RV_S;
    @(posedge clk);
    #1;
    chk_reset_vals("reset_held");
    @(negedge clk);
    en = 1'b0;
    rst_n = 1'b1;
  endtask

  // Monitor: every active edge the DUTs present new outputs; pop and compare.
  logic [W-1:0] prev_w = '0, prev_s = '0;
  always @(posedge clk) begin
    pair_t p;
    #1;
    if (q.size() > 0) begin
      p = q.pop_front();
      chk("w.bin", int'(bin_w), p.w.bin);
      chk("w.gray", int'(gray_w), p.w.gray);
      chk("w.at_max", int'(amax_w), int'(p.w.amax));
      chk("w.at_min", int'(amin_w), int'(p.w.amin));
      chk("w.wrap", int'(wrap_w), int'(p.w.wr));
      if (p.w.bitcheck) chk("w.gray_bits_changed", $countones(gray_w ^ prev_w), int'(p.w.chg));
      chk("s.bin", int'(bin_s), p.s.bin);
      chk("s.gray", int'(gray_s), p.s.gray);
      chk("s.at_max", int'(amax_s), int'(p.s.amax));
      chk("s.at_min", int'(amin_s), int'(p.s.amin));
      chk("s.wrap", int'(wrap_s), int'(p.s.wr));
      if (p.s.bitcheck) chk("s.gray_bits_changed", $countones(gray_s ^ prev_s), int'(p.s.chg));
    end
    prev_w = gray_w;
    prev_s = gray_s;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit d;
    #7 rst_n = 1'b0;
    #1;
    chk_reset_vals("power_on_reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Full up-count lap: wrap instance wraps once, saturate instance sticks at F.
    for (int i = 0; i < 18; i++) drive(0, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 1, 0);
    do_reset();

    // Down from 0, twice.
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0);

    // Load and priority.
    drive(0, 1, 0, 0, 4'b0111);
    drive(1, 1, 1, 1, 4'b1010);
    drive(0, 1, 1, 1, 4'b1000);

    // Saturate end points: up at F, then down at 0.
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 1, 0);
    drive(0, 1, 0, 0, 4'b0000);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 0);

    // Hold with dir toggling.
    drive(0, 1, 0, 0, 4'b1101);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, i[0], 0);

    // Direction reversal around 7/8.
    drive(0, 1, 0, 0, 4'b0100);
    for (int i = 0; i < 4; i++) drive(0, 0, 1, ~i[0], 0);

    // Randomised traffic with occasional mid-run reset.
    for (int i = 0; i < 400; i++) begin
      d = 1'(($urandom % 2));
      drive(($urandom % 20) == 0, ($urandom % 8) == 0, ($urandom % 4) != 0, d,
            int'($urandom % (MAXV + 1)));
      if (i == 200) do_reset();
    end

    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
